fan_offtimer_ctrl: RTL and testbench

Parametrised auto-off timer controller for the fan project. A single select pulse steps through a ring of timer presets: one "off" preset plus N−1 countdown presets. The block counts the selected time down in BCD MM:SS, supports pause, and emits a one-cycle timeout pulse at expiry so the fan power stage can shut down. It sits between the button conditioning logic (debounced edge pulses) and the FND/LED display drivers.

---
 rtl/fan_offtimer_ctrl.sv | 130 +++++++++++++
 tb/tb_fan_offtimer_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fan_offtimer_ctrl.sv
// Fan auto-off timer: select pulse rings through presets, BCD MM:SS
// countdown with pause, and a one-cycle timeout pulse on expiry.
module fan_offtimer_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int NUM_PRESETS = 4,
    parameter int STEP_MIN    = 10
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic                   sel_pulse,
    input  logic                   hold,
    output logic [2:0]             preset_idx,
    output logic [NUM_PRESETS-2:0] led_bar,
    output logic [15:0]            time_bcd,
    output logic                   running,
    output logic                   timeout
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_PRESETS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [2:0]    idx_next;

    assign idx_next = (preset_idx == IDX_LAST) ? 3'd0 : preset_idx + 3'd1;

    function automatic logic [NUM_PRESETS-2:0] therm(input logic [2:0] k);
        logic [NUM_PRESETS-2:0] t;
        t = '0;
        for (int i = 0; i < NUM_PRESETS - 1; i++)
            t[i] = (i < int'(k));
        return t;
    endfunction

    function automatic logic [15:0] preset_time(input logic [2:0] k);
        int m;
        m = int'(k) * STEP_MIN;
        return {4'(m / 10), 4'(m % 10), 8'h00};
    endfunction

    // Ripple borrow through sec1 -> sec10 -> min1 -> min10.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state      <= IDLE;
            prescaler  <= '0;
            preset_idx <= 3'd0;
            led_bar    <= '0;
            time_bcd   <= 16'h0000;
            running    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            // A select pulse overrides any tick or expiry on the same edge.
            if (sel_pulse) begin
                preset_idx <= idx_next;
                led_bar    <= therm(idx_next);
                time_bcd   <= preset_time(idx_next);
                prescaler  <= '0;
                if (idx_next == 3'd0) begin
                    state   <= IDLE;
                    running <= 1'b0;
                end else if (hold) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        if (hold) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (prescaler == PRE_TOP) begin
                            prescaler <= '0;
                            if (time_bcd == 16'h0001) begin
                                time_bcd   <= 16'h0000;
                                timeout    <= 1'b1;
                                preset_idx <= 3'd0;
                                led_bar    <= '0;
                                state      <= IDLE;
                                running    <= 1'b0;
                            end else begin
                                time_bcd <= bcd_dec(time_bcd);
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (!hold) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fan_offtimer_ctrl.sv
// Scoreboard bench for fan_offtimer_ctrl: stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_fan_offtimer_ctrl;

    localparam int TD = 4;
    localparam int NP = 4;
    localparam int SM = 1;

    localparam logic [4:0] M_IDX  = 5'd1;
    localparam logic [4:0] M_LED  = 5'd2;
    localparam logic [4:0] M_TIME = 5'd4;
    localparam logic [4:0] M_RUN  = 5'd8;
    localparam logic [4:0] M_TO   = 5'd16;
    localparam logic [4:0] M_ALL  = 5'h1f;

    logic          clk = 1'b0;
    logic          reset_p;
    logic          sel_pulse;
    logic          hold;
    logic [2:0]    preset_idx;
    logic [NP-2:0] led_bar;
    logic [15:0]   time_bcd;
    logic          running;
    logic          timeout;

    fan_offtimer_ctrl #(
        .TICK_DIV(TD),
        .NUM_PRESETS(NP),
        .STEP_MIN(SM)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .sel_pulse(sel_pulse),
        .hold(hold),
        .preset_idx(preset_idx),
        .led_bar(led_bar),
        .time_bcd(time_bcd),
        .running(running),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [4:0]  mask;
        logic [2:0]  idx;
        logic [2:0]  led;
        logic [15:0] tbcd;
        logic        run;
        logic        to;
    } exp_t;

    exp_t sbq[$];
    int checks   = 0;
    int failures = 0;
    int to_seen  = 0;

    task automatic push_exp(input int at, input string name,
                            input logic [4:0] mask, input logic [2:0] idx,
                            input logic [2:0] led, input logic [15:0] tbcd,
                            input logic run, input logic to);
        exp_t e;
        e.at = at; e.name = name; e.mask = mask; e.idx = idx;
        e.led = led; e.tbcd = tbcd; e.run = run; e.to = to;
        sbq.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        bit ok;
        ok = (e.at == cyc);
        if (e.mask[0] && preset_idx !== e.idx) ok = 0;
        if (e.mask[1] && led_bar !== e.led) ok = 0;
        if (e.mask[2] && time_bcd !== e.tbcd) ok = 0;
        if (e.mask[3] && running !== e.run) ok = 0;
        if (e.mask[4] && timeout !== e.to) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d(exp %0d) got idx=%0d led=%b time=%h run=%b to=%b want idx=%0d led=%b time=%h run=%b to=%b mask=%b",
                     e.name, cyc, e.at, preset_idx, led_bar, time_bcd, running,
                     timeout, e.idx, e.led, e.tbcd, e.run, e.to, e.mask);
        end
    endtask

    always @(negedge clk) begin
        if (timeout === 1'b1) to_seen++;
        for (int i = 0; i < sbq.size();) begin
            if (sbq[i].at <= cyc) begin
                compare(sbq[i]);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Inputs set on return take effect at posedge number e.
    task automatic go_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic sel_n(input int e, input int n);
        go_edge(e);
        sel_pulse = 1'b1;
        repeat (n) @(negedge clk);
        sel_pulse = 1'b0;
    endtask

    int l, l2, r, e;

    initial begin
        reset_p = 1'b1;
        sel_pulse = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        push_exp(cyc + 1, "reset", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        @(negedge clk);
        reset_p = 1'b0;

        // preset ring walk
        l = cyc + 2;
        push_exp(l, "load1", M_ALL, 1, 3'b001, 16'h0100, 1, 0);
        push_exp(l + 10, "load2", M_ALL, 2, 3'b011, 16'h0200, 1, 0);
        push_exp(l + 20, "load3", M_ALL, 3, 3'b111, 16'h0300, 1, 0);
        push_exp(l + 30, "load_off", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        push_exp(l + 36, "idle_hold", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        sel_n(l, 1);
        sel_n(l + 10, 1);
        sel_n(l + 20, 1);
        sel_n(l + 30, 1);
        go_edge(l + 36);
        hold = 1'b1;

        // load while hold is high goes straight to PAUSE
        l2 = l + 40;
        r = l2 + 10;
        push_exp(l2, "load_paused", M_ALL, 1, 3'b001, 16'h0100, 0, 0);
        push_exp(l2 + 8, "paused_frozen", M_TIME | M_RUN, 0, 0, 16'h0100, 0, 0);
        push_exp(r, "resume_run", M_TIME | M_RUN, 0, 0, 16'h0100, 1, 0);
        push_exp(r + 3, "resume_pre", M_TIME, 0, 0, 16'h0100, 0, 0);
        push_exp(r + 4, "resume_tick", M_TIME, 0, 0, 16'h0059, 0, 0);
        push_exp(r + 8, "wide_sel_off", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        sel_n(l2, 1);
        go_edge(r);
        hold = 1'b0;
        sel_n(r + 6, 3);

        // one-minute preset to expiry
        l = r + 12;
        push_exp(l, "p1_load", M_ALL, 1, 3'b001, 16'h0100, 1, 0);
        push_exp(l + 3, "p1_pre", M_TIME, 0, 0, 16'h0100, 0, 0);
        push_exp(l + 4, "p1_tick1", M_TIME, 0, 0, 16'h0059, 0, 0);
        push_exp(l + 7, "p1_hold1", M_TIME, 0, 0, 16'h0059, 0, 0);
        push_exp(l + 8, "p1_tick2", M_TIME, 0, 0, 16'h0058, 0, 0);
        push_exp(l + 239, "p1_last", M_ALL, 1, 3'b001, 16'h0001, 1, 0);
        push_exp(l + 240, "p1_expire", M_ALL, 0, 3'b000, 16'h0000, 0, 1);
        push_exp(l + 241, "p1_to_once", M_TO | M_RUN, 0, 0, 0, 0, 0);
        sel_n(l, 1);

        // preset 2 borrow chain
        l2 = l + 247;
        push_exp(l2, "p2_load", M_ALL, 2, 3'b011, 16'h0200, 1, 0);
        push_exp(l2 + 3, "p2_pre", M_TIME, 0, 0, 16'h0200, 0, 0);
        push_exp(l2 + 4, "p2_borrow", M_TIME, 0, 0, 16'h0159, 0, 0);
        push_exp(l2 + 200, "p2_0110", M_TIME, 0, 0, 16'h0110, 0, 0);
        push_exp(l2 + 236, "p2_0101", M_TIME, 0, 0, 16'h0101, 0, 0);
        push_exp(l2 + 240, "p2_0100", M_TIME, 0, 0, 16'h0100, 0, 0);
        push_exp(l2 + 244, "p2_0059", M_TIME, 0, 0, 16'h0059, 0, 0);
        push_exp(l2 + 247, "p2_off", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        sel_n(l2 - 1, 2);
        sel_n(l2 + 246, 2);

        // pause mid-tick and resume
        l = l2 + 250;
        r = l + 60;
        push_exp(l, "h_load", M_ALL, 1, 3'b001, 16'h0100, 1, 0);
        push_exp(l + 8, "h_two_ticks", M_TIME | M_RUN, 0, 0, 16'h0058, 1, 0);
        push_exp(l + 10, "h_paused", M_TIME | M_RUN, 0, 0, 16'h0058, 0, 0);
        push_exp(l + 40, "h_frozen", M_TIME | M_RUN, 0, 0, 16'h0058, 0, 0);
        push_exp(l + 59, "h_frozen_end", M_TIME | M_RUN, 0, 0, 16'h0058, 0, 0);
        push_exp(r, "h_release", M_TIME | M_RUN, 0, 0, 16'h0058, 1, 0);
        push_exp(r + 2, "h_pre_tick", M_TIME, 0, 0, 16'h0058, 0, 0);
        push_exp(r + 3, "h_tick", M_TIME, 0, 0, 16'h0057, 0, 0);
        // select collides with the expiry tick
        push_exp(r + 230, "c_last", M_ALL, 1, 3'b001, 16'h0001, 1, 0);
        push_exp(r + 231, "c_sel_wins", M_ALL, 2, 3'b011, 16'h0200, 1, 0);
        push_exp(r + 232, "c_no_to", M_TO, 0, 0, 0, 0, 0);
        push_exp(r + 235, "c_tick", M_TIME, 0, 0, 16'h0159, 0, 0);
        sel_n(l, 1);
        go_edge(l + 10);
        hold = 1'b1;
        go_edge(r);
        hold = 1'b0;
        sel_n(r + 231, 1);

        // reset mid-run
        e = r + 240;
        for (int k = 0; k < 6; k++)
            push_exp(e + k, "rst_mid", M_ALL, 0, 3'b000, 16'h0000, 0, 0);
        go_edge(e);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        while (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s never observed (due cyc %0d, now %0d)",
                     sbq[0].name, sbq[0].at, cyc);
            sbq.delete(0);
        end

        checks++;
        if (to_seen != 1) begin
            failures++;
            $display("FAIL timeout_count got=%0d want=1", to_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
